// File: rtl/udt_pkg.sv
// Shared constants, FSM state type and helpers for the UDT control-packet encoder.
// Control type codes follow the UDT wire format.
package udt_pkg;

    localparam logic [3:0] UDT_HANDSHAKE = 4'd0;
    localparam logic [3:0] UDT_KEEPALIVE = 4'd1;
    localparam logic [3:0] UDT_ACK       = 4'd2;
    localparam logic [3:0] UDT_NAK       = 4'd3;
    localparam logic [3:0] UDT_SHUTDOWN  = 4'd5;
    localparam logic [3:0] UDT_ACK2      = 4'd6;

    localparam int unsigned WORD_BITS = 32;
    localparam logic [7:0]  KEEP_FULL = 8'hFF;
    localparam logic [7:0]  KEEP_HALF = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR0    = 2'd1,
        ST_HDR1    = 2'd2,
        ST_PAYLOAD = 2'd3
    } enc_state_e;

    function automatic logic [3:0] pl_words(input logic [3:0] req_type,
                                            input logic       light,
                                            input logic       nak_range);
        logic [3:0] n;
        case (req_type)
            UDT_HANDSHAKE: n = 4'd12;
            UDT_ACK:       n = light ? 4'd1 : 4'd6;
            UDT_NAK:       n = nak_range ? 4'd2 : 4'd1;
            default:       n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic logic type_supported(input logic [3:0] req_type);
        logic ok;
        case (req_type)
            UDT_HANDSHAKE, UDT_KEEPALIVE, UDT_ACK,
            UDT_NAK, UDT_SHUTDOWN, UDT_ACK2: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] be32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] hdr_w0(input logic [3:0] req_type);
        return {1'b1, 11'd0, req_type, 16'h0000};
    endfunction

endpackage

// File: rtl/udt_ctrl_encode_if.sv
// Request bus and AXI-Stream output of the UDT control encoder.
// The encoder is the slave of requests and the master of the stream; modport names follow the request side.
interface udt_ctrl_encode_if #(
    parameter int unsigned MAX_PL_WORDS = 12
) ();
    logic                        req_valid;
    logic                        req_ready;
    logic [3:0]                  req_type;
    logic                        req_light;
    logic                        req_nak_range;
    logic [31:0]                 req_add_info;
    logic [31:0]                 req_dst_sock_id;
    logic [32*MAX_PL_WORDS-1:0]  req_data;
    logic [63:0]                 out_tdata;
    logic [7:0]                  out_tkeep;
    logic                        out_tvalid;
    logic                        out_tready;
    logic                        out_tlast;

    modport slave (
        input  req_valid, req_type, req_light, req_nak_range,
               req_add_info, req_dst_sock_id, req_data, out_tready,
        output req_ready, out_tdata, out_tkeep, out_tvalid, out_tlast
    );

    modport master (
        output req_valid, req_type, req_light, req_nak_range,
               req_add_info, req_dst_sock_id, req_data, out_tready,
        input  req_ready, out_tdata, out_tkeep, out_tvalid, out_tlast
    );
endinterface

// File: rtl/udt_us_timer.sv
// Free-running microsecond timestamp: a clock prescaler feeding a 32-bit wrapping counter.
// Shared with the receive-side RTT logic.
module udt_us_timer #(
    parameter int unsigned CLK_PER_US = 156
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] ts_o
);
    localparam logic [9:0] PRESC_LAST = 10'(CLK_PER_US - 32'd1);

    logic [9:0]  presc_q;
    logic [31:0] ts_q;

    // Prescaler and timestamp counter; the counter wraps naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= 10'd0;
            ts_q    <= 32'h0000_0000;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= 10'd0;
            ts_q    <= ts_q + 32'd1;
        end else begin
            presc_q <= presc_q + 10'd1;
        end
    end

    assign ts_o = ts_q;
endmodule

// File: rtl/udt_ctrl_encode.sv
// UDT control-packet encoder: captures a request, then streams the 128-bit header
// and the per-type payload as 64-bit big-endian AXI-Stream beats.
module udt_ctrl_encode
    import udt_pkg::*;
#(
    parameter int unsigned CLK_PER_US   = 156,
    parameter int unsigned MAX_PL_WORDS = 12
) (
    input  logic             core_clk,
    input  logic             core_rst_n,
    udt_ctrl_encode_if.slave bus,
    output logic             err_unsupported,
    output logic [31:0]      ts_now
);
    enc_state_e     state_q;
    logic           req_ready_q;
    logic           tvalid_q;
    logic           tlast_q;
    logic           err_q;
    logic [63:0]    tdata_q;
    logic [7:0]     tkeep_q;
    logic [31:0]    dst_q;
    logic [31:0]    ts_lat_q;
    logic [3:0]     n_q;
    logic [3:0]     idx_q;
    logic [31:0]    pl_q [MAX_PL_WORDS];

    logic [31:0]    req_pl_s [MAX_PL_WORDS];
    logic           accept_s;
    logic           beat_done_s;
    logic [3:0]     idx_hi_s;
    logic [3:0]     idx_next_s;
    logic [31:0]    pay_lo_s;
    logic [31:0]    pay_hi_s;
    logic [7:0]     pay_keep_s;
    logic           pay_last_s;

    udt_us_timer #(.CLK_PER_US(CLK_PER_US)) u_timer (
        .clk_i  (core_clk),
        .rst_ni (core_rst_n),
        .ts_o   (ts_now)
    );

    assign accept_s    = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;
    assign beat_done_s = tvalid_q && bus.out_tready;

    // Unpack the request payload; NAK word0 bit31 encodes single-loss vs range.
    always_comb begin
        for (int i = 0; i < MAX_PL_WORDS; i++) begin
            req_pl_s[i] = bus.req_data[WORD_BITS*i +: WORD_BITS];
        end
        if (bus.req_type == UDT_NAK) begin
            req_pl_s[0][31] = bus.req_nak_range;
        end else begin
            req_pl_s[0][31] = bus.req_data[31];
        end
    end

    // Next payload beat at idx_q; an odd final word leaves the upper half empty.
    always_comb begin
        idx_hi_s   = idx_q + 4'd1;
        idx_next_s = idx_q + 4'd2;
        pay_lo_s   = pl_q[idx_q];
        if (idx_hi_s < n_q) begin
            pay_hi_s   = pl_q[idx_hi_s];
            pay_keep_s = KEEP_FULL;
        end else begin
            pay_hi_s   = 32'h0000_0000;
            pay_keep_s = KEEP_HALF;
        end
        pay_last_s = (idx_next_s >= n_q);
    end

    // Packet FSM with registered stream outputs; outputs move only on a beat handshake.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            err_q       <= 1'b0;
            tdata_q     <= 64'h0;
            tkeep_q     <= 8'h00;
            dst_q       <= 32'h0000_0000;
            ts_lat_q    <= 32'h0000_0000;
            n_q         <= 4'd0;
            idx_q       <= 4'd0;
            for (int i = 0; i < MAX_PL_WORDS; i++) begin
                pl_q[i] <= 32'h0000_0000;
            end
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept_s) begin
                        if (type_supported(bus.req_type)) begin
                            req_ready_q <= 1'b0;
                            state_q     <= ST_HDR0;
                            tvalid_q    <= 1'b1;
                            tlast_q     <= 1'b0;
                            tkeep_q     <= KEEP_FULL;
                            tdata_q     <= {be32(bus.req_add_info), be32(hdr_w0(bus.req_type))};
                            dst_q       <= bus.req_dst_sock_id;
                            ts_lat_q    <= ts_now;
                            n_q         <= pl_words(bus.req_type, bus.req_light, bus.req_nak_range);
                            idx_q       <= 4'd0;
                            pl_q        <= req_pl_s;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_HDR0: begin
                    if (beat_done_s) begin
                        state_q <= ST_HDR1;
                        tdata_q <= {be32(dst_q), be32(ts_lat_q)};
                        tkeep_q <= KEEP_FULL;
                        tlast_q <= (n_q == 4'd0);
                    end
                end
                ST_HDR1, ST_PAYLOAD: begin
                    if (beat_done_s) begin
                        if (tlast_q) begin
                            state_q     <= ST_IDLE;
                            req_ready_q <= 1'b1;
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            tdata_q     <= 64'h0;
                            tkeep_q     <= 8'h00;
                        end else begin
                            state_q <= ST_PAYLOAD;
                            tdata_q <= {be32(pay_hi_s), be32(pay_lo_s)};
                            tkeep_q <= pay_keep_s;
                            tlast_q <= pay_last_s;
                            idx_q   <= idx_next_s;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                    tvalid_q    <= 1'b0;
                    tlast_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.out_tvalid  = tvalid_q;
    assign bus.out_tdata   = tdata_q;
    assign bus.out_tkeep   = tkeep_q;
    assign bus.out_tlast   = tlast_q;
    assign err_unsupported = err_q;
endmodule

// File: tb/tb_udt_ctrl_encode.sv
// Randomised self-checking bench for udt_ctrl_encode against a word-list packet model.
module tb_udt_ctrl_encode;
    localparam int CPU = 4;

    logic        core_clk = 1'b0;
    logic        core_rst_n = 1'b0;
    logic        err_unsupported;
    logic [31:0] ts_now;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc;
    logic [31:0] pl_tb [12];
    logic [63:0] exp_d [$];
    logic [7:0]  exp_k [$];
    logic        exp_l [$];
    logic [63:0] obs_d [$];

    udt_ctrl_encode_if #(.MAX_PL_WORDS(12)) bus ();

    udt_ctrl_encode #(.CLK_PER_US(CPU), .MAX_PL_WORDS(12)) dut (
        .core_clk        (core_clk),
        .core_rst_n      (core_rst_n),
        .bus             (bus),
        .err_unsupported (err_unsupported),
        .ts_now          (ts_now)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) cyc <= 0;
        else             cyc <= cyc + 1;
    end

    function automatic logic [31:0] swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic int n_payload(input logic [3:0] t, input logic light, input logic nakr);
        if (t == 4'd0) return 12;
        if (t == 4'd2) return light ? 1 : 6;
        if (t == 4'd3) return nakr ? 2 : 1;
        return 0;
    endfunction

    // Packet = header words then payload words, paired two per beat, each word byte-swapped.
    task automatic build_expected(input logic [3:0] t, input logic light, input logic nakr,
                                  input logic [31:0] add, input logic [31:0] dst, input logic [31:0] ts);
        logic [31:0] w [$];
        logic [31:0] x;
        logic [31:0] hi;
        int n;
        int nb;
        exp_d.delete(); exp_k.delete(); exp_l.delete();
        w.push_back(32'h8000_0000 | (32'(t) << 16));
        w.push_back(add);
        w.push_back(ts);
        w.push_back(dst);
        n = n_payload(t, light, nakr);
        for (int i = 0; i < n; i++) begin
            x = pl_tb[i];
            if (t == 4'd3 && i == 0) x[31] = nakr;
            w.push_back(x);
        end
        nb = (w.size() + 1) / 2;
        for (int b = 0; b < nb; b++) begin
            if (2*b + 1 < w.size()) begin
                hi = w[2*b+1];
                exp_k.push_back(8'hFF);
            end else begin
                hi = 32'h0;
                exp_k.push_back(8'h0F);
            end
            exp_d.push_back({swap(hi), swap(w[2*b])});
            exp_l.push_back(b == nb - 1);
        end
    endtask

    task automatic send_req(input logic [3:0] t, input logic light, input logic nakr,
                            input logic [31:0] add, input logic [31:0] dst);
        int guard;
        guard = 0;
        @(negedge core_clk);
        bus.req_type        = t;
        bus.req_light       = light;
        bus.req_nak_range   = nakr;
        bus.req_add_info    = add;
        bus.req_dst_sock_id = dst;
        for (int i = 0; i < 12; i++) bus.req_data[32*i +: 32] = pl_tb[i];
        bus.req_valid = 1'b1;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge core_clk);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            failures++;
            $display("FAIL req_accept: req_ready got %b required 1 within 50 cycles", bus.req_ready);
        end
        build_expected(t, light, nakr, add, dst, 32'(cyc / CPU));
        @(posedge core_clk);
        #1;
        bus.req_valid       = 1'b0;
        bus.req_type        = 4'($urandom);
        bus.req_light       = 1'($urandom);
        bus.req_nak_range   = 1'($urandom);
        bus.req_add_info    = $urandom;
        bus.req_dst_sock_id = $urandom;
        for (int i = 0; i < 12; i++) bus.req_data[32*i +: 32] = $urandom;
    endtask

    task automatic collect(input int ready_pct, input string name);
        int got;
        int guard;
        logic stall;
        logic [63:0] pd;
        logic [7:0] pk;
        logic pl;
        got = 0; guard = 0; stall = 1'b0; pd = 64'h0; pk = 8'h0; pl = 1'b0;
        obs_d.delete();
        while (got < exp_d.size() && guard < 400) begin
            @(negedge core_clk);
            if (guard == 0) begin
                checks++;
                if (bus.out_tvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL %s latency: tvalid got %b required 1", name, bus.out_tvalid);
                end
            end
            if (stall) begin
                checks++;
                if ({bus.out_tdata, bus.out_tkeep, bus.out_tlast} !== {pd, pk, pl}) begin
                    failures++;
                    $display("FAIL %s hold: got %h/%h/%b required %h/%h/%b", name,
                             bus.out_tdata, bus.out_tkeep, bus.out_tlast, pd, pk, pl);
                end
            end
            if (bus.out_tvalid === 1'b1) begin
                checks++;
                if (bus.req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s busy_ready: req_ready got %b required 0", name, bus.req_ready);
                end
            end
            bus.out_tready = ($urandom_range(0, 99) < ready_pct);
            if (bus.out_tvalid === 1'b1 && bus.out_tready) begin
                checks++;
                if ({bus.out_tdata, bus.out_tkeep, bus.out_tlast} !== {exp_d[got], exp_k[got], exp_l[got]}) begin
                    failures++;
                    $display("FAIL %s beat%0d: got %h/%h/%b required %h/%h/%b", name, got,
                             bus.out_tdata, bus.out_tkeep, bus.out_tlast, exp_d[got], exp_k[got], exp_l[got]);
                end
                obs_d.push_back(bus.out_tdata);
                got++;
            end
            stall = (bus.out_tvalid === 1'b1) && !bus.out_tready;
            pd = bus.out_tdata; pk = bus.out_tkeep; pl = bus.out_tlast;
            guard++;
        end
        checks++;
        if (got < exp_d.size()) begin
            failures++;
            $display("FAIL %s timeout: beats got %0d required %0d", name, got, exp_d.size());
        end
        @(negedge core_clk);
        bus.out_tready = 1'b0;
        checks++;
        if (bus.out_tvalid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s gap: tvalid/req_ready got %b/%b required 0/1", name, bus.out_tvalid, bus.req_ready);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < 12; i++) pl_tb[i] = $urandom;
    endtask

    task automatic test_reset();
        core_rst_n = 1'b0;
        repeat (3) @(negedge core_clk);
        checks++;
        if ({bus.req_ready, bus.out_tvalid, bus.out_tlast, bus.out_tdata, bus.out_tkeep, err_unsupported, ts_now} !== 108'h0) begin
            failures++;
            $display("FAIL reset_vals: rdy=%b tv=%b tl=%b td=%h tk=%h err=%b ts=%h required all 0",
                     bus.req_ready, bus.out_tvalid, bus.out_tlast, bus.out_tdata, bus.out_tkeep, err_unsupported, ts_now);
        end
        core_rst_n = 1'b1;
        @(negedge core_clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_keepalive();
        rand_payload();
        send_req(4'd1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
        collect(100, "keepalive");
        checks++;
        if (obs_d.size() < 2 || obs_d[0] !== 64'h00000000_00000180 || obs_d[1] !== 64'h78563412_00000000) begin
            failures++;
            $display("FAIL keepalive_const: got %0d beats b0=%h b1=%h required 00000000_00000180 78563412_00000000",
                     obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : 64'h0, (obs_d.size() > 1) ? obs_d[1] : 64'h0);
        end
    endtask

    task automatic test_ack();
        rand_payload();
        for (int i = 0; i < 6; i++) pl_tb[i] = 32'(i + 1);
        send_req(4'd2, 1'b0, 1'b0, 32'd7, $urandom);
        collect(100, "ack");
        rand_payload();
        send_req(4'd2, 1'b1, 1'b0, $urandom, $urandom);
        collect(70, "light_ack");
    endtask

    task automatic test_nak();
        rand_payload();
        pl_tb[0] = 32'h0000_0010;
        send_req(4'd3, 1'b0, 1'b1, 32'h0, $urandom);
        collect(100, "nak_range");
        checks++;
        if (obs_d.size() < 3 || swap(obs_d[2][31:0]) !== 32'h8000_0010) begin
            failures++;
            $display("FAIL nak_range_w0: got %h required 80000010", (obs_d.size() > 2) ? swap(obs_d[2][31:0]) : 32'h0);
        end
        rand_payload();
        pl_tb[0] = 32'h8000_0010;
        send_req(4'd3, 1'b0, 1'b0, 32'h0, $urandom);
        collect(80, "nak_single");
        checks++;
        if (obs_d.size() < 3 || swap(obs_d[2][31:0]) !== 32'h0000_0010) begin
            failures++;
            $display("FAIL nak_single_w0: got %h required 00000010", (obs_d.size() > 2) ? swap(obs_d[2][31:0]) : 32'h0);
        end
    endtask

    task automatic test_handshake();
        rand_payload();
        send_req(4'd0, 1'b0, 1'b0, 32'h0, $urandom);
        collect(50, "handshake");
    endtask

    task automatic test_back_to_back();
        logic [3:0] types [6];
        types = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6};
        for (int k = 0; k < 8; k++) begin
            rand_payload();
            send_req(types[$urandom_range(0, 5)], 1'($urandom), 1'($urandom), $urandom, $urandom);
            collect($urandom_range(40, 100), "b2b");
        end
    endtask

    task automatic test_unsupported();
        logic [3:0] bad [2];
        bad[0] = 4'd4;
        bad[1] = 4'($urandom_range(7, 15));
        for (int k = 0; k < 2; k++) begin
            send_req(bad[k], 1'b0, 1'b0, $urandom, $urandom);
            @(negedge core_clk);
            checks++;
            if (err_unsupported !== 1'b1 || bus.out_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL unsup_pulse type %0d: err/tvalid got %b/%b required 1/0", bad[k], err_unsupported, bus.out_tvalid);
            end
            @(negedge core_clk);
            checks++;
            if (err_unsupported !== 1'b0 || bus.out_tvalid !== 1'b0 || bus.req_ready !== 1'b1) begin
                failures++;
                $display("FAIL unsup_after: err/tvalid/rdy got %b/%b/%b required 0/0/1", err_unsupported, bus.out_tvalid, bus.req_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_payload();
        send_req(4'd2, 1'b0, 1'b0, 32'd9, $urandom);
        bus.out_tready = 1'b1;
        repeat (3) @(negedge core_clk);
        checks++;
        if (bus.out_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: tvalid got %b required 1", bus.out_tvalid);
        end
        core_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_tvalid !== 1'b0 || bus.out_tlast !== 1'b0 || ts_now !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_clear: tvalid/tlast/ts got %b/%b/%h required 0/0/0", bus.out_tvalid, bus.out_tlast, ts_now);
        end
        bus.out_tready = 1'b0;
        @(negedge core_clk);
        core_rst_n = 1'b1;
        @(negedge core_clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_ready: got %b required 1", bus.req_ready);
        end
        rand_payload();
        send_req(4'd2, 1'b0, 1'b0, 32'd10, $urandom);
        collect(100, "after_rst");
    endtask

    task automatic test_timestamp();
        logic [31:0] w2;
        core_rst_n = 1'b0;
        @(negedge core_clk);
        core_rst_n = 1'b1;
        repeat (4000) @(negedge core_clk);
        send_req(4'd1, 1'b0, 1'b0, 32'h0, $urandom);
        collect(100, "timestamp");
        w2 = (obs_d.size() > 1) ? swap(obs_d[1][31:0]) : 32'h0;
        checks++;
        if (w2 < 32'd999 || w2 > 32'd1001) begin
            failures++;
            $display("FAIL ts_1000: W2 got %0d required 1000 +-1", w2);
        end
    endtask

    task automatic test_ts_wrap();
        int guard;
        guard = 0;
        @(negedge core_clk);
        force dut.u_timer.ts_q = 32'hFFFF_FFFF;
        @(negedge core_clk);
        release dut.u_timer.ts_q;
        #1;
        checks++;
        if (ts_now !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL ts_forced: got %h required ffffffff", ts_now);
        end
        while (ts_now === 32'hFFFF_FFFF && guard < 3 * CPU) begin
            @(negedge core_clk);
            guard++;
        end
        checks++;
        if (ts_now !== 32'h0) begin
            failures++;
            $display("FAIL ts_wrap: got %h required 00000000", ts_now);
        end
    endtask

    initial begin
        bus.req_valid       = 1'b0;
        bus.req_type        = 4'd0;
        bus.req_light       = 1'b0;
        bus.req_nak_range   = 1'b0;
        bus.req_add_info    = 32'h0;
        bus.req_dst_sock_id = 32'h0;
        bus.req_data        = '0;
        bus.out_tready      = 1'b0;
        for (int i = 0; i < 12; i++) pl_tb[i] = 32'h0;
        test_reset();
        test_keepalive();
        test_ack();
        test_nak();
        test_handshake();
        test_back_to_back();
        test_unsupported();
        test_reset_mid();
        test_timestamp();
        test_ts_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/udt_ctrl_encode.md
Name: udt_ctrl_encode

Overview:
Transmit-side counterpart of the UDT receive decoder. It builds UDT control packets (handshake, keep-alive, ACK, light ACK, NAK, shutdown, ACK2) from a single-cycle request bus, and serialises them as 64-bit AXI-Stream beats toward the UDP TX path.
The 128-bit UDT control header is generated internally, including a free-running microsecond timestamp. The per-type control-info payload is appended with correct tkeep/tlast.

Parameters:
CLK_PER_US, 156, core_clk cycles per microsecond tick of the timestamp counter (range 1..1023).
MAX_PL_WORDS, 12, maximum payload 32-bit words (handshake size); fixes the width of req_data.

Ports:
core_clk  in  1  single clock for all logic
core_rst_n  in  1  asynchronous active-low reset (fixed decision: one clock, async active-low reset)
req_valid  in  1  control-packet request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_type  in  4  UDT control type code: 0 handshake, 1 keep-alive, 2 ACK, 3 NAK, 5 shutdown, 6 ACK2
req_light  in  1  ACK only: 1 = light ACK (1 payload word)
req_nak_range  in  1  NAK only: 0 = single loss (1 word), 1 = range (2 words)
req_add_info  in  32  header additional-info field (ACK seq no. for ACK/ACK2, else 0)
req_dst_sock_id  in  32  header destination socket ID
req_data  in  32*MAX_PL_WORDS  payload; word i = req_data[32i+31:32i]
out_tdata  out  64  packet beat; packet byte k of a beat on [8k+7:8k]
out_tkeep  out  8  byte valid: 8'hFF, or 8'h0F on an odd-word last beat
out_tvalid  out  1  beat valid
out_tready  in  1  downstream ready
out_tlast  out  1  last beat of packet
err_unsupported  out  1  one-cycle pulse: unsupported req_type was accepted and dropped
ts_now  out  32  current microsecond timestamp (for RTT use by other blocks)

Behaviour:
- Reset values: req_ready=0, out_tvalid=0, out_tlast=0, out_tdata=0, out_tkeep=0, err_unsupported=0, ts_now=0, FSM=IDLE. req_ready rises the first cycle after reset release.
- Timestamp: prescaler counts 0..CLK_PER_US-1. On terminal count, ts_now increments by 1 and wraps 2^32-1 -> 0. The timestamp is latched at request acceptance, not at transmit.
- Byte order: every 32-bit field is big-endian on the wire. The MS byte is the lowest packet byte, so beat word0 occupies bytes 0-3 ([31:0]) and word1 occupies bytes 4-7 ([63:32]).
- Header words: W0={1'b1, req_type zero-extended to 15 bits, 16'h0}, W1=add_info, W2=latched timestamp, W3=dst_sock_id.
- Payload words (N):
  - handshake: 12
  - ACK: 6; light ACK: 1
  - NAK single: 1, with bit31 of word0 forced to 0
  - NAK range: 2, with bit31 of word0 forced to 1
  - keep-alive, shutdown, ACK2: 0
- Beat count = ceil((4+N)/2). The last beat carries tkeep 8'h0F when (4+N) is odd, and its upper 32 bits are 0.
- FSM states: IDLE -> HDR0 -> HDR1 -> PAYLOAD (skipped when N=0) -> IDLE.
  - IDLE: req_ready=1. On accept, all request fields are captured into registers and the next state is HDR0, with out_tvalid=1 on the next cycle. Request latency is 1 cycle.
  - In HDR0/HDR1/PAYLOAD: req_ready=0. A beat advances only on out_tvalid && out_tready.
  - While out_tready=0, out_tdata/tkeep/tlast are held stable.
  - After the tlast handshake: out_tvalid drops and the FSM returns to IDLE. The minimum inter-packet gap is 1 cycle.
- Unsupported req_type (4, 7..15): the request is accepted and err_unsupported pulses 1 cycle later. No beat is emitted and the FSM stays in IDLE.
- Input changes after accept have no effect on the packet in flight.
- Reset mid-packet: outputs clear immediately (async), truncating the packet without tlast. Downstream discards it. The timestamp restarts at 0.
- Payload word index is a 4-bit counter (0..11); it is never compared past N.

Decomposition:
- Package udt_pkg holds:
  - type constants (UDT_HANDSHAKE=0, KEEPALIVE=1, ACK=2, NAK=3, SHUTDOWN=5, ACK2=6)
  - header width constants
  - FSM state enum
  - function pl_words(type, light, nak_range) returning N
  - function be32(x) for byte swap
- One sub-module: udt_us_timer (prescaler plus 32-bit wrap counter, outputs ts_now). It is reusable by the receive-side RTT logic.

Test Plan:
- Keep-alive, dst_sock_id=32'h12345678, ts=0, out_tready=1 -> 2 beats.
  - beat0 tdata=64'h00000000_00000180
  - beat1 tdata=64'h78563412_00000000, tkeep=FF, tlast=1
- ACK (add_info=7, 6 payload words 1..6) -> 5 beats, last tkeep=FF. Light ACK -> 3 beats, last tkeep=0F, upper 32 bits 0.
- NAK range, word0=32'h00000010 -> word0 on wire 32'h80000010, 3 beats, last tkeep=FF. NAK single, word0=32'h80000010 -> wire 32'h00000010, last tkeep=0F.
- Handshake with random out_tready (50%) -> 8 beats, data held stable during stalls, req_ready=0 throughout, tlast only on beat 8.
- CLK_PER_US=4; run 4000 cycles, then issue a request -> header W2 = 1000 (±1). Force ts_now to 32'hFFFFFFFF, then one tick -> 0.
- req_type=4 -> err_unsupported=1 for one cycle, no out_tvalid. Assert core_rst_n=0 at beat 3 of an ACK -> out_tvalid=0 immediately; after release, req_ready=1 and the next packet is complete.
